// File: rtl/sd_pkg.sv
// Shared definitions for the SD host command controller: FSM states,
// response-type codes, command framing start bits and error classes.
package sd_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_TO, ERR_IDX} err_t;

  localparam logic [1:0] RESP_NONE     = 2'b00;
  localparam logic [1:0] RESP_SHORT    = 2'b01;
  localparam logic [1:0] RESP_LONG     = 2'b10;
  localparam logic [1:0] RESP_SHORT_NC = 2'b11;

  localparam logic [1:0] CMD_START = 2'b01;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Response-wait timer: counts enabled cycles from zero, saturates at all-ones,
// and flags when the count equals the programmed limit.
module cmd_timeout_timer import sd_pkg::*; #(
  parameter int TO_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            hit
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + TO_W'(1);
  end

  assign hit = (count == limit);

endmodule

// File: rtl/cmd_controller_mr.sv
// SD host CMD-line controller: frames index/argument, hands it to the PHY,
// collects none/short/long responses with optional index check and bounded retry.
module cmd_controller_mr import sd_pkg::*; #(
  parameter int          ARG_W     = 32,
  parameter int          RESP_W    = 128,
  parameter int          IN_W      = 136,
  parameter int          TO_W      = 32,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_command,
  input  logic [ARG_W-1:0]   cmd_argument,
  input  logic [5:0]         cmd_index,
  input  logic [1:0]         resp_type,
  input  logic [TO_W-1:0]    command_timeout_REG,
  input  logic               tx_done,
  input  logic               strobe_in,
  input  logic [IN_W-1:0]    cmd_in,
  output logic [ARG_W+7:0]   cmd_out,
  output logic               strobe_out,
  output logic               ack_out,
  output logic               idle_out,
  output logic               busy,
  output logic [RESP_W-1:0]  response,
  output logic               command_complete,
  output logic               command_timeout,
  output logic               command_index_error,
  output logic [1:0]         retry_count
);

  state_t state, state_nxt;
  err_t   err_q, err_nxt, fail;

  logic [5:0]        sh_idx;
  logic [1:0]        sh_type;
  logic [TO_W-1:0]   sh_tout;
  logic              hit, accept, retry, ack_nxt, start;
  logic [RESP_W-1:0] resp_nxt;
  logic              unused_bits;

  assign unused_bits = ^cmd_in[IN_W-1:RESP_W];
  assign start       = (state == IDLE) && new_command;

  cmd_timeout_timer #(.TO_W(TO_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .limit  (sh_tout),
    .hit    (hit)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    fail      = ERR_NONE;
    accept    = 1'b0;
    retry     = 1'b0;
    ack_nxt   = 1'b0;
    case (state)
      IDLE: if (new_command) begin
        state_nxt = SEND;
        err_nxt   = ERR_NONE;
      end
      SEND: if (tx_done) state_nxt = (sh_type == RESP_NONE) ? DONE : WAIT;
      WAIT: begin
        // A response arriving on the timeout cycle takes precedence.
        if (strobe_in) begin
          ack_nxt = 1'b1;
          if ((sh_type == RESP_SHORT) && (cmd_in[ARG_W+5:ARG_W] != sh_idx))
            fail = ERR_IDX;
          else begin
            accept    = 1'b1;
            state_nxt = DONE;
          end
        end else if (hit)
          fail = ERR_TO;
        if (fail != ERR_NONE) begin
          if (retry_count < 2'(MAX_RETRY)) begin
            retry     = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = DONE;
            err_nxt   = fail;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_nxt = {{(RESP_W-ARG_W){1'b0}}, cmd_in[ARG_W-1:0]};
    case (sh_type)
      RESP_LONG:                resp_nxt = cmd_in[RESP_W-1:0];
      RESP_SHORT, RESP_SHORT_NC: resp_nxt = {{(RESP_W-ARG_W){1'b0}}, cmd_in[ARG_W-1:0]};
      default:                  resp_nxt = {{(RESP_W-ARG_W){1'b0}}, cmd_in[ARG_W-1:0]};
    endcase
  end

  // Shadow copies of the request; only meaningful once a command is accepted.
  always_ff @(posedge clock) begin
    if (start) begin
      sh_idx  <= cmd_index;
      sh_type <= resp_type;
      sh_tout <= command_timeout_REG;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      err_q               <= ERR_NONE;
      retry_count         <= '0;
      cmd_out             <= '0;
      strobe_out          <= 1'b0;
      ack_out             <= 1'b0;
      idle_out            <= 1'b1;
      busy                <= 1'b0;
      response            <= '0;
      command_complete    <= 1'b0;
      command_timeout     <= 1'b0;
      command_index_error <= 1'b0;
    end else begin
      state               <= state_nxt;
      err_q               <= err_nxt;
      strobe_out          <= (state_nxt == SEND);
      idle_out            <= (state_nxt == IDLE);
      busy                <= (state_nxt != IDLE);
      ack_out             <= ack_nxt;
      command_complete    <= (state == DONE) && (err_q == ERR_NONE);
      command_timeout     <= (state == DONE) && (err_q == ERR_TO);
      command_index_error <= (state == DONE) && (err_q == ERR_IDX);
      if (start) begin
        cmd_out     <= {CMD_START, cmd_index, cmd_argument};
        response    <= '0;
        retry_count <= '0;
      end
      if (accept) response    <= resp_nxt;
      if (retry)  retry_count <= retry_count + 2'd1;
    end
  end

endmodule

// File: tb/tb_cmd_controller_mr.sv
// Directed bench for cmd_controller_mr: short/long/no-response commands,
// timeout retries, index-error retry, busy rejection and asynchronous reset.
module tb_cmd_controller_mr;

  localparam int ARG_W = 32, RESP_W = 128, IN_W = 136, TO_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              new_command = 1'b0;
  logic [ARG_W-1:0]  cmd_argument = '0;
  logic [5:0]        cmd_index = '0;
  logic [1:0]        resp_type = '0;
  logic [TO_W-1:0]   command_timeout_REG = '0;
  logic              tx_done = 1'b0;
  logic              strobe_in = 1'b0;
  logic [IN_W-1:0]   cmd_in = '0;
  logic [ARG_W+7:0]  cmd_out;
  logic              strobe_out, ack_out, idle_out, busy;
  logic [RESP_W-1:0] response;
  logic              command_complete, command_timeout, command_index_error;
  logic [1:0]        retry_count;

  int checks = 0, errors = 0;
  int n_ack = 0, n_cc = 0, n_to = 0, n_idx = 0, n_send = 0;
  int s_ack, s_cc, s_to, s_idx, s_send;
  logic strobe_prev = 1'b0;

  cmd_controller_mr #(.ARG_W(ARG_W), .RESP_W(RESP_W), .IN_W(IN_W), .TO_W(TO_W), .MAX_RETRY(2)) dut (
    .clock(clock), .reset(reset), .new_command(new_command), .cmd_argument(cmd_argument),
    .cmd_index(cmd_index), .resp_type(resp_type), .command_timeout_REG(command_timeout_REG),
    .tx_done(tx_done), .strobe_in(strobe_in), .cmd_in(cmd_in), .cmd_out(cmd_out),
    .strobe_out(strobe_out), .ack_out(ack_out), .idle_out(idle_out), .busy(busy),
    .response(response), .command_complete(command_complete), .command_timeout(command_timeout),
    .command_index_error(command_index_error), .retry_count(retry_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ack_out) n_ack++;
    if (command_complete) n_cc++;
    if (command_timeout) n_to++;
    if (command_index_error) n_idx++;
    if (strobe_out && !strobe_prev) n_send++;
    strobe_prev = strobe_out;
  end

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [135:0] short_frame(input logic [5:0] i, input logic [31:0] a);
    return {96'b0, 2'b00, i, a};
  endfunction

  task automatic snap();
    s_ack = n_ack; s_cc = n_cc; s_to = n_to; s_idx = n_idx; s_send = n_send;
  endtask

  task automatic start_cmd(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                           input logic [31:0] to);
    @(negedge clock);
    cmd_index = i; cmd_argument = a; resp_type = t; command_timeout_REG = to;
    new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    chk("start_busy", busy, 1'b1);
  endtask

  task automatic serve_sends(input int n);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!strobe_out && w < 50) begin @(negedge clock); w++; end
      chk("send_seen", strobe_out, 1'b1);
      tx_done = 1'b1;
      @(negedge clock);
      tx_done = 1'b0;
    end
  endtask

  task automatic respond(input logic [135:0] frame);
    cmd_in = frame; strobe_in = 1'b1;
    @(negedge clock);
    strobe_in = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!idle_out && w < 200) begin @(negedge clock); w++; end
    chk("idle_wait", idle_out, 1'b1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_idle", idle_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", strobe_out, 1'b0);
    chk("rst_cmd_out", cmd_out, 40'h0);
    chk("rst_resp", response, 128'h0);
    reset = 1'b1;

    // 1: short response with index check, busy request ignored
    snap();
    start_cmd(6'd8, 32'h1AA, 2'b01, 32'd100);
    chk("t1_cmd_out", cmd_out, 40'h48_000001AA);
    chk("t1_strobe", strobe_out, 1'b1);
    chk("t1_idle_low", idle_out, 1'b0);
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    chk("t1_wait_strobe", strobe_out, 1'b0);
    cmd_index = 6'd3; cmd_argument = 32'hFFFF; new_command = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    chk("t1_busy_ignored", cmd_out, 40'h48_000001AA);
    respond(136'h08_000001AA);
    chk("t1_ack", ack_out, 1'b1);
    chk("t1_resp", response, 128'h1AA);
    chk("t1_cc_early", command_complete, 1'b0);
    @(negedge clock);
    chk("t1_cc", command_complete, 1'b1);
    chk("t1_idle", idle_out, 1'b1);
    @(negedge clock);
    chk("t1_cc_pulse", command_complete, 1'b0);
    wait_idle();
    chk("t1_n_ack", n_ack - s_ack, 1);
    chk("t1_n_cc", n_cc - s_cc, 1);

    // 2: long response, index field ignored
    snap();
    start_cmd(6'd2, 32'h0, 2'b10, 32'd100);
    serve_sends(1);
    respond({8'hFF, 128'hDEAD0000_11112222_33334444_5555BEEF});
    wait_idle();
    chk("t2_resp", response, 128'hDEAD0000_11112222_33334444_5555BEEF);
    chk("t2_n_idx", n_idx - s_idx, 0);
    chk("t2_n_cc", n_cc - s_cc, 1);

    // 3: timeout=5 with two retries
    snap();
    start_cmd(6'd17, 32'h1234, 2'b01, 32'd5);
    serve_sends(3);
    wait_idle();
    chk("t3_n_send", n_send - s_send, 3);
    chk("t3_retry", retry_count, 2'd2);
    chk("t3_n_to", n_to - s_to, 1);
    chk("t3_n_cc", n_cc - s_cc, 0);

    // 4: index mismatch then match
    snap();
    start_cmd(6'd5, 32'h0, 2'b01, 32'd50);
    serve_sends(1);
    respond(short_frame(6'd6, 32'h0BAD));
    chk("t4_ack_mis", ack_out, 1'b1);
    chk("t4_retry1", retry_count, 2'd1);
    serve_sends(1);
    respond(short_frame(6'd5, 32'h12345678));
    wait_idle();
    chk("t4_resp", response, 128'h12345678);
    chk("t4_retry", retry_count, 2'd1);
    chk("t4_n_cc", n_cc - s_cc, 1);
    chk("t4_n_idx", n_idx - s_idx, 0);
    chk("t4_n_ack", n_ack - s_ack, 2);

    // 5: no-response command
    snap();
    start_cmd(6'd0, 32'h0, 2'b00, 32'd10);
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    chk("t5_cc_1", command_complete, 1'b0);
    @(negedge clock);
    chk("t5_cc_2", command_complete, 1'b1);
    respond(short_frame(6'd0, 32'h77));
    @(negedge clock);
    chk("t5_no_ack", n_ack - s_ack, 0);
    chk("t5_resp_clr", response, 128'h0);

    // 7: timeout of zero expires on the first wait cycle of every attempt
    snap();
    start_cmd(6'd1, 32'h0, 2'b11, 32'd0);
    serve_sends(3);
    wait_idle();
    chk("t7_n_to", n_to - s_to, 1);
    chk("t7_n_send", n_send - s_send, 3);

    // 6: asynchronous reset in WAIT after a retry
    start_cmd(6'd12, 32'h55, 2'b01, 32'd200);
    serve_sends(1);
    respond(short_frame(6'd13, 32'h0));
    serve_sends(1);
    @(negedge clock);
    chk("t6_pre_retry", retry_count, 2'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_idle", idle_out, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_retry", retry_count, 2'd0);
    chk("t6_rst_cmd", cmd_out, 40'h0);
    @(negedge clock);
    reset = 1'b1;
    snap();
    start_cmd(6'd9, 32'hCAFE, 2'b11, 32'd20);
    chk("t6_cmd_out", cmd_out, 40'h49_0000CAFE);
    serve_sends(1);
    respond(short_frame(6'd1, 32'hABCD));
    wait_idle();
    chk("t6_resp", response, 128'hABCD);
    chk("t6_retry", retry_count, 2'd0);
    chk("t6_n_cc", n_cc - s_cc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
